// File: rtl/dmx4x16_frame_pkg.sv
// ---------------------------------------------------------------------------
// dmx4x16_frame_pkg
// Shared slot numbering and default word width for the 4-way frame
// demultiplexer. The slot constants match the select encoding of the
// 4-way selector on the transmit side (S=n selects D<n>), so word n of a
// frame always lands in channel n.
// ---------------------------------------------------------------------------
package dmx4x16_frame_pkg;

   typedef logic [1:0] slot_t;

   localparam slot_t SLOT_CH0 = 2'd0;
   localparam slot_t SLOT_CH1 = 2'd1;
   localparam slot_t SLOT_CH2 = 2'd2;
   localparam slot_t SLOT_CH3 = 2'd3;

   localparam int DEFAULT_WIDTH = 16;

endpackage

// File: rtl/dmx4x16_frame_slot_ctr.sv
// ---------------------------------------------------------------------------
// slot_ctr
// 2-bit frame slot counter.
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset, counter to slot 0
//   en    : data valid; advances the counter by one slot
//   load  : frame marker; restarts counting at slot 0
//   slot  : slot the next valid word will fill
//   tc    : terminal count, the current valid word completes a frame
// ---------------------------------------------------------------------------
module slot_ctr
   import dmx4x16_frame_pkg::*;
(
   input  logic  clk,
   input  logic  rst,
   input  logic  en,
   input  logic  load,
   output slot_t slot,
   output logic  tc
);

   slot_t slot_q;
   slot_t slot_d;
   slot_t slot_base;

   // A frame marker restarts the frame at slot 0. When it comes with a
   // valid word, that word occupies slot 0, so the counter lands on slot 1.
   always_comb begin
      slot_base = load ? SLOT_CH0 : slot_q;
      slot_d    = slot_base + slot_t'(en);
      tc        = (slot_q == SLOT_CH3) && en && !load;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_q <= SLOT_CH0;
      end else begin
         slot_q <= slot_d;
      end
   end

   assign slot = slot_q;

endmodule

// File: rtl/dmx4x16_frame.sv
// ---------------------------------------------------------------------------
// dmx4x16_frame
// Frame-aligned 1-to-4 demultiplexer. Words arriving one per valid strobe
// are steered into slots 0..3; slots 0..2 are held in staging registers and
// all four channel outputs are updated together when slot 3 arrives, so the
// outputs always hold one coherent frame.
//   CLK        : system clock, rising edge
//   RST        : synchronous active-high reset
//   D          : input word
//   DV         : data valid, D captured when high
//   SYNC       : frame marker, restarts the frame at slot 0
//   Y0..Y3     : channels 0..3 of the last complete frame
//   VO         : one-cycle pulse, Y0..Y3 just updated
//   SLOT       : slot the next valid word will fill
//   ERR        : one-cycle pulse, partial frame discarded by SYNC
// ---------------------------------------------------------------------------
module dmx4x16_frame
   import dmx4x16_frame_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] D,
   input  logic             DV,
   input  logic             SYNC,
   output logic [WIDTH-1:0] Y0,
   output logic [WIDTH-1:0] Y1,
   output logic [WIDTH-1:0] Y2,
   output logic [WIDTH-1:0] Y3,
   output logic             VO,
   output logic [1:0]       SLOT,
   output logic             ERR
);

   slot_t slot;
   slot_t eff_slot;
   logic  frame_done;

   logic [WIDTH-1:0] s0_q, s1_q, s2_q;
   logic [WIDTH-1:0] s0_d, s1_d, s2_d;
   logic [WIDTH-1:0] y0_q, y1_q, y2_q, y3_q;
   logic [WIDTH-1:0] y0_d, y1_d, y2_d, y3_d;
   logic             vo_q, vo_d;
   logic             err_q, err_d;

   slot_ctr u_slot_ctr (
      .clk  (CLK),
      .rst  (RST),
      .en   (DV),
      .load (SYNC),
      .slot (slot),
      .tc   (frame_done)
   );

   // A word arriving with SYNC is always slot 0, whatever the counter says.
   // The fourth word is not staged: it goes straight to Y3 while the three
   // staged words move to Y0..Y2 on the same edge.
   always_comb begin
      eff_slot = SYNC ? SLOT_CH0 : slot;
      s0_d     = s0_q;
      s1_d     = s1_q;
      s2_d     = s2_q;
      y0_d     = y0_q;
      y1_d     = y1_q;
      y2_d     = y2_q;
      y3_d     = y3_q;
      if (DV) begin
         case (eff_slot)
            SLOT_CH0: s0_d = D;
            SLOT_CH1: s1_d = D;
            SLOT_CH2: s2_d = D;
            default:  ;
         endcase
      end
      if (frame_done) begin
         y0_d = s0_q;
         y1_d = s1_q;
         y2_d = s2_q;
         y3_d = D;
      end
      vo_d  = frame_done;
      err_d = SYNC && (slot != SLOT_CH0);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         s0_q  <= '0;
         s1_q  <= '0;
         s2_q  <= '0;
         y0_q  <= '0;
         y1_q  <= '0;
         y2_q  <= '0;
         y3_q  <= '0;
         vo_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         s0_q  <= s0_d;
         s1_q  <= s1_d;
         s2_q  <= s2_d;
         y0_q  <= y0_d;
         y1_q  <= y1_d;
         y2_q  <= y2_d;
         y3_q  <= y3_d;
         vo_q  <= vo_d;
         err_q <= err_d;
      end
   end

   assign Y0   = y0_q;
   assign Y1   = y1_q;
   assign Y2   = y2_q;
   assign Y3   = y3_q;
   assign VO   = vo_q;
   assign ERR  = err_q;
   assign SLOT = slot;

endmodule

// File: tb/tb_dmx4x16_frame.sv
// ---------------------------------------------------------------------------
// tb_dmx4x16_frame
// Self-checking bench for dmx4x16_frame: a hand-filled vector table for the
// directed sequences, then gapped and random traffic checked against a
// frame-level reference model (a queue of words in the current frame).
// ---------------------------------------------------------------------------
module tb_dmx4x16_frame;

   logic        CLK;
   logic        RST;
   logic [15:0] D;
   logic        DV;
   logic        SYNC;
   logic [15:0] Y0, Y1, Y2, Y3;
   logic        VO;
   logic [1:0]  SLOT;
   logic        ERR;

   int checks;
   int failures;

   dmx4x16_frame #(.WIDTH(16)) dut (
      .CLK  (CLK),
      .RST  (RST),
      .D    (D),
      .DV   (DV),
      .SYNC (SYNC),
      .Y0   (Y0),
      .Y1   (Y1),
      .Y2   (Y2),
      .Y3   (Y3),
      .VO   (VO),
      .SLOT (SLOT),
      .ERR  (ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Reference model: the words collected so far in the current frame, plus
   // the last complete frame and the two pulses.
   logic [15:0] mWords[$];
   logic [15:0] mY[4];
   bit          mVo;
   bit          mErr;

   typedef struct {
      bit          rst;
      bit          dv;
      bit          sync;
      logic [15:0] d;
      logic [15:0] y0, y1, y2, y3;
      bit          vo;
      bit          err;
      logic [1:0]  slot;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit r, bit dv, bit sy, logic [15:0] d,
                               logic [15:0] y0, logic [15:0] y1,
                               logic [15:0] y2, logic [15:0] y3,
                               bit vo, bit err, logic [1:0] slot);
      vec_t v;
      v.rst = r; v.dv = dv; v.sync = sy; v.d = d;
      v.y0 = y0; v.y1 = y1; v.y2 = y2; v.y3 = y3;
      v.vo = vo; v.err = err; v.slot = slot;
      return v;
   endfunction

   task automatic modelStep(input bit r, input bit dv, input bit sy,
                            input logic [15:0] d);
      if (r) begin
         mWords.delete();
         for (int i = 0; i < 4; i++) mY[i] = 16'h0000;
         mVo  = 1'b0;
         mErr = 1'b0;
      end else begin
         mVo  = 1'b0;
         mErr = 1'b0;
         if (sy) begin
            if (mWords.size() != 0) mErr = 1'b1;
            mWords.delete();
         end
         if (dv) begin
            mWords.push_back(d);
            if (mWords.size() == 4) begin
               for (int i = 0; i < 4; i++) mY[i] = mWords[i];
               mVo = 1'b1;
               mWords.delete();
            end
         end
      end
   endtask

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, advance the model, sample 1 ns after the edge.
   task automatic applyStimulus(input bit r, input bit dv, input bit sy,
                                input logic [15:0] d);
      RST  = r;
      DV   = dv;
      SYNC = sy;
      D    = d;
      @(posedge CLK);
      modelStep(r, dv, sy, d);
      #1;
   endtask

   task automatic checkOutput(input string tag);
      check({tag, " Y0"},   Y0, mY[0]);
      check({tag, " Y1"},   Y1, mY[1]);
      check({tag, " Y2"},   Y2, mY[2]);
      check({tag, " Y3"},   Y3, mY[3]);
      check({tag, " VO"},   {15'd0, VO},  {15'd0, mVo});
      check({tag, " ERR"},  {15'd0, ERR}, {15'd0, mErr});
      check({tag, " SLOT"}, {14'd0, SLOT}, 16'(mWords.size()));
   endtask

   int voSeen;
   int errSeen;

   initial begin
      checks   = 0;
      failures = 0;
      RST = 1'b1; DV = 1'b0; SYNC = 1'b0; D = 16'h0000;

      // Continuous frame, then a SYNC-truncated frame
      vecs.push_back(mk(1,0,0,16'h0000, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,2'd0));
      vecs.push_back(mk(0,1,0,16'h1111, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,2'd1));
      vecs.push_back(mk(0,1,0,16'h2222, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,2'd2));
      vecs.push_back(mk(0,1,0,16'h3333, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,2'd3));
      vecs.push_back(mk(0,1,0,16'h4444, 16'h1111,16'h2222,16'h3333,16'h4444, 1,0,2'd0));
      vecs.push_back(mk(0,0,0,16'h0000, 16'h1111,16'h2222,16'h3333,16'h4444, 0,0,2'd0));
      vecs.push_back(mk(0,1,0,16'h0001, 16'h1111,16'h2222,16'h3333,16'h4444, 0,0,2'd1));
      vecs.push_back(mk(0,1,0,16'h0002, 16'h1111,16'h2222,16'h3333,16'h4444, 0,0,2'd2));
      vecs.push_back(mk(0,1,1,16'hBEEF, 16'h1111,16'h2222,16'h3333,16'h4444, 0,1,2'd1));
      vecs.push_back(mk(0,1,0,16'hC001, 16'h1111,16'h2222,16'h3333,16'h4444, 0,0,2'd2));
      vecs.push_back(mk(0,1,0,16'hC002, 16'h1111,16'h2222,16'h3333,16'h4444, 0,0,2'd3));
      vecs.push_back(mk(0,1,0,16'hC003, 16'hBEEF,16'hC001,16'hC002,16'hC003, 1,0,2'd0));
      // SYNC without DV at slot 2, then at slot 0, then SYNC+DV at slot 0
      vecs.push_back(mk(0,1,0,16'h5555, 16'hBEEF,16'hC001,16'hC002,16'hC003, 0,0,2'd1));
      vecs.push_back(mk(0,1,0,16'h6666, 16'hBEEF,16'hC001,16'hC002,16'hC003, 0,0,2'd2));
      vecs.push_back(mk(0,0,1,16'h0000, 16'hBEEF,16'hC001,16'hC002,16'hC003, 0,1,2'd0));
      vecs.push_back(mk(0,0,0,16'h0000, 16'hBEEF,16'hC001,16'hC002,16'hC003, 0,0,2'd0));
      vecs.push_back(mk(0,0,1,16'h0000, 16'hBEEF,16'hC001,16'hC002,16'hC003, 0,0,2'd0));
      vecs.push_back(mk(0,1,1,16'h7777, 16'hBEEF,16'hC001,16'hC002,16'hC003, 0,0,2'd1));
      vecs.push_back(mk(0,1,0,16'h8888, 16'hBEEF,16'hC001,16'hC002,16'hC003, 0,0,2'd2));
      vecs.push_back(mk(0,1,0,16'h9999, 16'hBEEF,16'hC001,16'hC002,16'hC003, 0,0,2'd3));
      vecs.push_back(mk(0,1,0,16'hAAAA, 16'h7777,16'h8888,16'h9999,16'hAAAA, 1,0,2'd0));
      // Reset in the middle of a frame discards it without ERR
      vecs.push_back(mk(1,0,0,16'h0000, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,2'd0));
      vecs.push_back(mk(0,1,0,16'h00D1, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,2'd1));
      vecs.push_back(mk(0,1,0,16'h00D2, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,2'd2));
      vecs.push_back(mk(0,1,0,16'h00D3, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,2'd3));
      vecs.push_back(mk(1,1,0,16'h00D4, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,2'd0));
      vecs.push_back(mk(0,1,0,16'h0E01, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,2'd1));
      vecs.push_back(mk(0,1,0,16'h0E02, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,2'd2));
      vecs.push_back(mk(0,1,0,16'h0E03, 16'h0000,16'h0000,16'h0000,16'h0000, 0,0,2'd3));
      vecs.push_back(mk(0,1,0,16'h0E04, 16'h0E01,16'h0E02,16'h0E03,16'h0E04, 1,0,2'd0));
      vecs.push_back(mk(0,0,0,16'h0000, 16'h0E01,16'h0E02,16'h0E03,16'h0E04, 0,0,2'd0));

      $display("[TB] directed vector table, %0d rows", vecs.size());
      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rst, vecs[i].dv, vecs[i].sync, vecs[i].d);
         check($sformatf("row%0d Y0", i),   Y0, vecs[i].y0);
         check($sformatf("row%0d Y1", i),   Y1, vecs[i].y1);
         check($sformatf("row%0d Y2", i),   Y2, vecs[i].y2);
         check($sformatf("row%0d Y3", i),   Y3, vecs[i].y3);
         check($sformatf("row%0d VO", i),   {15'd0, VO},  {15'd0, vecs[i].vo});
         check($sformatf("row%0d ERR", i),  {15'd0, ERR}, {15'd0, vecs[i].err});
         check($sformatf("row%0d SLOT", i), {14'd0, SLOT}, {14'd0, vecs[i].slot});
      end

      // Gapped DV: one valid word every third cycle
      $display("[TB] gapped DV frame");
      applyStimulus(1, 0, 0, 16'h0000);
      checkOutput("gap reset");
      voSeen = 0;
      for (int w = 0; w < 4; w++) begin
         applyStimulus(0, 1, 0, 16'hA000 + 16'(w));
         checkOutput($sformatf("gap w%0d", w));
         if (VO) voSeen++;
         for (int g = 0; g < 2; g++) begin
            applyStimulus(0, 0, 0, 16'h0000);
            checkOutput($sformatf("gap w%0d idle%0d", w, g));
            if (VO) voSeen++;
         end
      end
      check("gap Y0 final", Y0, 16'hA000);
      check("gap Y3 final", Y3, 16'hA003);
      check("gap VO count", 16'(voSeen), 16'd1);

      // 64 random frames at continuous DV
      $display("[TB] random frames");
      voSeen  = 0;
      errSeen = 0;
      for (int f = 0; f < 64; f++) begin
         for (int w = 0; w < 4; w++) begin
            applyStimulus(0, 1, 0, 16'($urandom));
            checkOutput($sformatf("rnd f%0d w%0d", f, w));
            if (VO) voSeen++;
            if (ERR) errSeen++;
         end
      end
      check("rnd VO count",  16'(voSeen),  16'd64);
      check("rnd ERR count", 16'(errSeen), 16'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
